wash_cycle_controller: RTL and testbench



---
 rtl/wash_pkg.sv | 28 ++
 rtl/wash_cycle_controller_phase_timer.sv | 67 ++++++
 rtl/wash_cycle_controller.sv | 150 +++++++++++++++
 tb/tb_wash_cycle_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wash_pkg
// Description : Shared definitions for the washing-machine sequencer:
//               3-bit phase encoding and default phase durations (seconds).
// Revision    : 1.0 - initial release
// ============================================================================
package wash_pkg;

  localparam int unsigned c_PHASE_W = 3;

  // Default phase durations in seconds
  localparam int unsigned c_FILL_SEC_DEF  = 120;
  localparam int unsigned c_WASH_SEC_DEF  = 300;
  localparam int unsigned c_RINSE_SEC_DEF = 120;
  localparam int unsigned c_SPIN_SEC_DEF  = 60;

  // Encoding is visible on the phase output, so values are fixed
  typedef enum logic [c_PHASE_W-1:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4
  } phase_e;

endpackage
`default_nettype wire

// File: rtl/wash_cycle_controller_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Phase duration timer. On load it captures
//               target = dur_sec * CYC_PER_SEC_MHZ * f (f=0 treated as 1),
//               computed at 2*CNT_W bits and saturated to CNT_W bits, and
//               clears the counter. Counts while en=1; tc flags the last
//               cycle of the phase (a target of 0 behaves as 1).
// Ports       : clk, rst_n     - clock, async active-low reset
//               load           - capture new target, clear counter
//               dur_sec        - phase duration in seconds
//               freq_mhz       - clock frequency code in MHz
//               en             - count enable
//               clear          - clear counter (target kept)
//               tc             - terminal count (counter == target-1)
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned CYC_PER_SEC_MHZ = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] dur_sec,
  input  logic [3:0]       freq_mhz,
  input  logic             en,
  input  logic             clear,
  output logic             tc
);

  localparam int unsigned c_PROD_W = 2 * CNT_W;
  localparam logic [c_PROD_W-1:0] c_CYC = c_PROD_W'(CYC_PER_SEC_MHZ);

  logic [3:0]          w_freq;
  logic [c_PROD_W-1:0] w_prod;
  logic [CNT_W-1:0]    w_target_sat;
  logic [CNT_W-1:0]    w_last;
  logic [CNT_W-1:0]    r_target;
  logic [CNT_W-1:0]    r_count;

  always_comb begin
    w_freq       = (freq_mhz == 4'd0) ? 4'd1 : freq_mhz;
    w_prod       = c_PROD_W'(dur_sec) * c_CYC * c_PROD_W'(w_freq);
    w_target_sat = (|w_prod[c_PROD_W-1:CNT_W]) ? {CNT_W{1'b1}} : w_prod[CNT_W-1:0];
    // Zero target would never match target-1; treat it as a 1-cycle phase
    w_last       = (r_target == '0) ? '0 : r_target - CNT_W'(1);
  end

  assign tc = (r_count == w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
      r_count  <= '0;
    end else if (load) begin
      r_target <= w_target_sat;
      r_count  <= '0;
    end else if (clear) begin
      r_count  <= '0;
    end else if (en) begin
      r_count  <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wash_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : wash_cycle_controller
// Description : Coin-started washing sequencer: FILL -> WASH -> RINSE
//               [-> WASH -> RINSE when double wash] -> SPIN -> IDLE.
//               Each phase lasts duration_sec * CYC_PER_SEC_MHZ * f cycles,
//               with the target sampled at phase entry.
// Ports       : clk, rst_n          - clock, async active-low reset
//               clock_frequency_dec - clock frequency in MHz (0 -> 1)
//               coin_in             - start request (IDLE only)
//               double_wash         - second wash+rinse, latched with coin
//               timer_pause         - freeze, honoured in SPIN only
//               phase               - current phase (registered)
//               wash_done           - cycle completed level (registered)
//               door_closed/door_lock - present only with WASH_DOOR_LOCK_EN
// Config      : `define WASH_DOOR_LOCK_EN adds the door interlock.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_cycle_controller
  import wash_pkg::*;
#(
  parameter int unsigned FILL_SEC        = c_FILL_SEC_DEF,
  parameter int unsigned WASH_SEC        = c_WASH_SEC_DEF,
  parameter int unsigned RINSE_SEC       = c_RINSE_SEC_DEF,
  parameter int unsigned SPIN_SEC        = c_SPIN_SEC_DEF,
  parameter int unsigned CYC_PER_SEC_MHZ = 1000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] clock_frequency_dec,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       timer_pause,
  output logic [2:0] phase,
  output logic       wash_done
`ifdef WASH_DOOR_LOCK_EN
  ,
  input  logic       door_closed,
  output logic       door_lock
`endif
);

  phase_e           r_phase;
  logic             r_dbl;
  logic             r_second;
  logic             r_done;

  logic             w_door_ok;
  logic             w_run;
  logic             w_coin;
  logic             w_tc;
  logic             w_advance;
  phase_e           w_next;
  logic             w_load;
  logic             w_clear;
  logic [CNT_W-1:0] w_load_sec;

`ifdef WASH_DOOR_LOCK_EN
  logic r_door_lock;
  assign w_door_ok = door_closed;
  assign door_lock = r_door_lock;
`else
  assign w_door_ok = 1'b1;
`endif

  always_comb begin
    w_run   = (r_phase != PH_IDLE) && w_door_ok &&
              !((r_phase == PH_SPIN) && timer_pause);
    w_coin  = (r_phase == PH_IDLE) && coin_in && w_door_ok;
    w_advance = w_run && w_tc;

    case (r_phase)
      PH_FILL:  w_next = PH_WASH;
      PH_WASH:  w_next = PH_RINSE;
      PH_RINSE: w_next = (r_dbl && !r_second) ? PH_WASH : PH_SPIN;
      PH_SPIN:  w_next = PH_IDLE;
      default:  w_next = PH_IDLE;
    endcase

    // Duration of the phase about to be entered
    if (w_coin) begin
      w_load_sec = CNT_W'(FILL_SEC);
    end else begin
      case (w_next)
        PH_WASH:  w_load_sec = CNT_W'(WASH_SEC);
        PH_RINSE: w_load_sec = CNT_W'(RINSE_SEC);
        PH_SPIN:  w_load_sec = CNT_W'(SPIN_SEC);
        default:  w_load_sec = CNT_W'(FILL_SEC);
      endcase
    end

    w_load  = w_coin || (w_advance && (w_next != PH_IDLE));
    w_clear = w_advance && (w_next == PH_IDLE);
  end

  phase_timer #(
    .CNT_W           (CNT_W),
    .CYC_PER_SEC_MHZ (CYC_PER_SEC_MHZ)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .dur_sec  (w_load_sec),
    .freq_mhz (clock_frequency_dec),
    .en       (w_run),
    .clear    (w_clear),
    .tc       (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= PH_IDLE;
      r_dbl    <= 1'b0;
      r_second <= 1'b0;
      r_done   <= 1'b0;
    end else if (w_coin) begin
      r_phase  <= PH_FILL;
      r_dbl    <= double_wash;
      // A new cycle must be allowed its own second pass
      r_second <= 1'b0;
      r_done   <= 1'b0;
    end else if (w_advance) begin
      r_phase <= w_next;
      if ((r_phase == PH_RINSE) && (w_next == PH_WASH)) begin
        r_second <= 1'b1;
      end
      if (w_next == PH_IDLE) begin
        r_done <= 1'b1;
      end
    end
  end

`ifdef WASH_DOOR_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_door_lock <= 1'b0;
    end else if (w_coin) begin
      r_door_lock <= 1'b1;
    end else if (w_advance && (w_next == PH_IDLE)) begin
      r_door_lock <= 1'b0;
    end
  end
`endif

  assign phase     = r_phase;
  assign wash_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_wash_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_wash_cycle_controller
// Description : Self-checking bench for wash_cycle_controller. Each scenario
//               pushes the expected (phase, wash_done) per clock edge into a
//               queue and compares it against the DUT after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wash_cycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] freq = 4'd1;
  logic       coin_in = 1'b0;
  logic       double_wash = 1'b0;
  logic       timer_pause = 1'b0;
  logic [2:0] phase;
  logic       wash_done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] ph;
    logic       done;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  wash_cycle_controller #(
    .FILL_SEC        (2),
    .WASH_SEC        (3),
    .RINSE_SEC       (2),
    .SPIN_SEC        (1),
    .CYC_PER_SEC_MHZ (1),
    .CNT_W           (32)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .clock_frequency_dec (freq),
    .coin_in             (coin_in),
    .double_wash         (double_wash),
    .timer_pause         (timer_pause),
    .phase               (phase),
    .wash_done           (wash_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_phase(input int p, input int sec, input int f);
    exp_t e;
    int   fe;
    fe = (f == 0) ? 1 : f;
    e.ph = 3'(p);
    e.done = 1'b0;
    for (int i = 0; i < sec * fe; i++) q.push_back(e);
  endfunction

  // Cycle complete: IDLE with wash_done held for a few cycles
  function automatic void push_end();
    exp_t e;
    e.ph = 3'd0;
    e.done = 1'b1;
    for (int i = 0; i < 3; i++) q.push_back(e);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    coin_in = 1'b1;
    tick();
    tick();
    n_vec++;
    if (phase !== 3'd0 || wash_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: phase=%0d done=%0d, required phase=0 done=0", phase, wash_done);
    end
    coin_in = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if (phase !== 3'd0 || wash_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: phase=%0d done=%0d, required phase=0 done=0", phase, wash_done);
    end
  endtask

  task automatic test_single(input logic [3:0] f, input string name);
    exp_t e;
    freq = f;
    push_phase(1, 2, f);
    push_phase(2, 3, f);
    push_phase(3, 2, f);
    push_phase(4, 1, f);
    push_end();
    coin_in = 1'b1;
    for (int j = 0; q.size() > 0 && j < 200; j++) begin
      tick();
      coin_in = 1'b0;
      e = q.pop_front();
      n_vec++;
      if (phase !== e.ph || wash_done !== e.done) begin
        n_err++;
        $display("FAIL %s step %0d: phase=%0d done=%0d, required phase=%0d done=%0d",
                 name, j, phase, wash_done, e.ph, e.done);
      end
    end
  endtask

  task automatic test_double_wash();
    exp_t e;
    freq = 4'd1;
    push_phase(1, 2, 1);
    push_phase(2, 3, 1);
    push_phase(3, 2, 1);
    push_phase(2, 3, 1);
    push_phase(3, 2, 1);
    push_phase(4, 1, 1);
    push_end();
    coin_in = 1'b1;
    double_wash = 1'b1;
    for (int j = 0; q.size() > 0 && j < 200; j++) begin
      tick();
      coin_in = 1'b0;
      double_wash = 1'b0;
      e = q.pop_front();
      n_vec++;
      if (phase !== e.ph || wash_done !== e.done) begin
        n_err++;
        $display("FAIL double_wash step %0d: phase=%0d done=%0d, required phase=%0d done=%0d",
                 j, phase, wash_done, e.ph, e.done);
      end
    end
  endtask

  // Pause held across edges 8..12 while in SPIN stretches SPIN by 5 cycles
  task automatic test_pause_spin();
    exp_t e;
    freq = 4'd1;
    push_phase(1, 2, 1);
    push_phase(2, 3, 1);
    push_phase(3, 2, 1);
    push_phase(4, 6, 1);
    push_end();
    for (int j = 0; q.size() > 0 && j < 200; j++) begin
      coin_in = (j == 0);
      timer_pause = (j >= 8 && j <= 12);
      tick();
      e = q.pop_front();
      n_vec++;
      if (phase !== e.ph || wash_done !== e.done) begin
        n_err++;
        $display("FAIL pause_spin step %0d: phase=%0d done=%0d, required phase=%0d done=%0d",
                 j, phase, wash_done, e.ph, e.done);
      end
    end
    coin_in = 1'b0;
    timer_pause = 1'b0;
  endtask

  // Coin and pause while in WASH must both be ignored
  task automatic test_ignored_in_wash();
    exp_t e;
    freq = 4'd1;
    push_phase(1, 2, 1);
    push_phase(2, 3, 1);
    push_phase(3, 2, 1);
    push_phase(4, 1, 1);
    push_end();
    for (int j = 0; q.size() > 0 && j < 200; j++) begin
      coin_in = (j == 0 || j == 3 || j == 4);
      timer_pause = (j == 3 || j == 4);
      tick();
      e = q.pop_front();
      n_vec++;
      if (phase !== e.ph || wash_done !== e.done) begin
        n_err++;
        $display("FAIL ignored_in_wash step %0d: phase=%0d done=%0d, required phase=%0d done=%0d",
                 j, phase, wash_done, e.ph, e.done);
      end
    end
    coin_in = 1'b0;
    timer_pause = 1'b0;
  endtask

  // Frequency 1 -> 4 mid-WASH: WASH keeps its target, later phases use f=4
  task automatic test_freq_change();
    exp_t e;
    freq = 4'd1;
    push_phase(1, 2, 1);
    push_phase(2, 3, 1);
    push_phase(3, 2, 4);
    push_phase(4, 1, 4);
    push_end();
    for (int j = 0; q.size() > 0 && j < 200; j++) begin
      coin_in = (j == 0);
      if (j == 3) freq = 4'd4;
      tick();
      e = q.pop_front();
      n_vec++;
      if (phase !== e.ph || wash_done !== e.done) begin
        n_err++;
        $display("FAIL freq_change step %0d: phase=%0d done=%0d, required phase=%0d done=%0d",
                 j, phase, wash_done, e.ph, e.done);
      end
    end
    coin_in = 1'b0;
    freq = 4'd1;
  endtask

  task automatic test_reset_mid_cycle();
    exp_t e;
    freq = 4'd1;
    push_phase(1, 2, 1);
    push_phase(2, 3, 1);
    push_phase(3, 1, 1);
    for (int j = 0; q.size() > 0 && j < 200; j++) begin
      coin_in = (j == 0);
      tick();
      e = q.pop_front();
      n_vec++;
      if (phase !== e.ph || wash_done !== e.done) begin
        n_err++;
        $display("FAIL reset_mid_pre step %0d: phase=%0d done=%0d, required phase=%0d done=%0d",
                 j, phase, wash_done, e.ph, e.done);
      end
    end
    coin_in = 1'b0;
    // Asynchronous reset mid-RINSE, checked before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (phase !== 3'd0 || wash_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_async: phase=%0d done=%0d, required phase=0 done=0", phase, wash_done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (phase !== 3'd0 || wash_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_no_resume: phase=%0d done=%0d, required phase=0 done=0", phase, wash_done);
    end
    test_single(4'd1, "restart_after_reset");
    // Reset in IDLE with wash_done high must clear it
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (wash_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_clears_done: done=%0d, required done=0", wash_done);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single(4'd1, "single_f1");
    test_single(4'd2, "single_f2");
    test_single(4'd0, "single_f0");
    test_double_wash();
    test_single(4'd1, "single_after_double");
    test_pause_spin();
    test_ignored_in_wash();
    test_reset_mid_cycle();
    test_freq_change();
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
